ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) to the keyboard over the shared open-drain ps2_clk and ps2_data lines. It sits beside the PS/2 receiver on the same pins, performs the request-to-send sequence, shifts the frame out on device-generated clocks, and checks the device ACK. Line drivers are external tri-states: a drive_low output set to 1 pulls the line low; 0 releases it.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_edge_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame constants and the
// frame builder used by the transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int unsigned FRAME_BITS  = 10;  // 8 data + parity + stop
  localparam int unsigned ACK_FALL    = 11;  // device falling edge that carries the ACK
  localparam int unsigned SYNC_STAGES = 3;
  localparam int unsigned BITCNT_W    = 4;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] frame_bits(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronizer plus falling-edge detector for a raw PS/2 line.
// Ports:
//   clk, clrn  - system clock, async active-low reset
//   raw        - asynchronous line input
//   level      - synchronized line level
//   fall_c     - one-cycle strobe on a synchronized high-to-low transition
module ps2_edge_sync
  import ps2_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic clrn,
  input  logic raw,
  output logic level,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;

  // Reset to all ones: an idle PS/2 line is high, so no fake edge on exit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], raw};
    end
  end

  assign level  = sync_q[STAGES-2];
  assign fall_c = sync_q[STAGES-1] & ~sync_q[STAGES-2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift on device
// clocks, ACK check, and a watchdog on missing device clocks.
// Ports:
//   clk, clrn            - system clock, async active-low reset
//   tx_data, tx_valid    - command byte and send request
//   tx_ready             - high only when idle; accept on tx_valid & tx_ready
//   ps2_clk, ps2_data    - raw open-drain lines (asynchronous)
//   ps2_*_drive_low      - 1 pulls the matching line low via external tri-state
//   busy                 - high in every state except idle
//   done/ack_err/timeout - one-cycle completion pulses
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                       INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  ps2_state_e          state_q, state_d;
  logic [9:0]          shift_q, shift_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tx_ready_d, busy_d, done_d, ack_err_d, timeout_d;
  logic                clk_drv_d, data_drv_d;

  logic                clk_level, clk_fall_c;
  logic [1:0]          data_sync_q;
  logic                data_level;

  ps2_edge_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .clrn   (clrn),
    .raw    (ps2_clk),
    .level  (clk_level),
    .fall_c (clk_fall_c)
  );

  // Data line only needs its level, so a plain 2-flop synchronizer.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end
  assign data_level = data_sync_q[1];

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q            <= IDLE;
      shift_q            <= '0;
      bitcnt_q           <= '0;
      cnt_q              <= '0;
      tx_ready           <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      ack_err            <= 1'b0;
      timeout            <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
    end else begin
      state_q            <= state_d;
      shift_q            <= shift_d;
      bitcnt_q           <= bitcnt_d;
      cnt_q              <= cnt_d;
      tx_ready           <= tx_ready_d;
      busy               <= busy_d;
      done               <= done_d;
      ack_err            <= ack_err_d;
      timeout            <= timeout_d;
      ps2_clk_drive_low  <= clk_drv_d;
      ps2_data_drive_low <= data_drv_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    cnt_d      = cnt_q;
    clk_drv_d  = ps2_clk_drive_low;
    data_drv_d = ps2_data_drive_low;
    tx_ready_d = 1'b0;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_d    = frame_bits(tx_data);
          bitcnt_d   = '0;
          cnt_d      = '0;
          clk_drv_d  = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_drv_d = 1'b1;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          data_drv_d = 1'b1;  // start bit
          cnt_d      = '0;
          state_d    = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b1;
        cnt_d      = '0;
        state_d    = SHIFT;
      end

      SHIFT: begin
        clk_drv_d = 1'b0;
        if (clk_fall_c) begin
          data_drv_d = ~shift_q[0];
          shift_d    = {1'b1, shift_q[9:1]};
          bitcnt_d   = bitcnt_q + BITCNT_W'(1);
          cnt_d      = '0;
          if (bitcnt_q == BITCNT_W'(FRAME_BITS - 1)) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        if (clk_fall_c) begin
          bitcnt_d = BITCNT_W'(ACK_FALL);
          cnt_d    = '0;
          done_d    = ~data_level;
          ack_err_d = data_level;
          state_d  = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        if (clk_level && data_level) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d    = IDLE;
            tx_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    // Device clock watchdog; the idle cycle after a timeout keeps tx_ready low
    // so the pulse never coincides with ready.
    if ((state_q == SHIFT || state_q == ACK) && !clk_fall_c) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        clk_drv_d  = 1'b0;
        data_drv_d = 1'b0;
        timeout_d  = 1'b1;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural keyboard device,
// and a frame reference built from the byte's population count.
module tb_ps2_host_tx;

  localparam int unsigned INH = 8;
  localparam int unsigned TMO = 64;

  logic       clk;
  logic       clrn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       busy, done, ack_err, timeout;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk, ps2_data;

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0, ack_err_cnt = 0, timeout_cnt = 0, viol_cnt = 0;
  int half = 20;

  assign ps2_clk  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .clrn               (clrn),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .ps2_clk            (ps2_clk),
    .ps2_data           (ps2_data),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low),
    .busy               (busy),
    .done               (done),
    .ack_err            (ack_err),
    .timeout            (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse bookkeeping: counts and exclusivity violations.
  always @(negedge clk) begin
    if (done === 1'b1)    done_cnt    <= done_cnt + 1;
    if (ack_err === 1'b1) ack_err_cnt <= ack_err_cnt + 1;
    if (timeout === 1'b1) timeout_cnt <= timeout_cnt + 1;
    if ((int'(done) + int'(ack_err) + int'(timeout) > 1) ||
        ((done | ack_err | timeout) && tx_ready))
      viol_cnt <= viol_cnt + 1;
  end

  // Reference frame: data LSB first, odd parity from the count of ones, stop 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Cycles the host holds clock low before it drives the start bit.
  task automatic measure_inhibit(output int n);
    int guard;
    n = 0;
    guard = 0;
    while (ps2_clk_drive_low === 1'b1 && ps2_data_drive_low === 1'b0 && guard < 200) begin
      n++;
      guard++;
      @(negedge clk);
    end
  endtask

  // Keyboard model: waits for request-to-send, clocks 11 times, samples each
  // bit on the rising edge, drives the ACK before the 11th falling edge.
  task automatic device_run(input bit ack_low, input int abort_after, output logic [9:0] got);
    int guard;
    got   = '0;
    guard = 0;
    while (!(ps2_clk_drive_low === 1'b0 && ps2_data_drive_low === 1'b1) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    nvec++;
    if (guard >= 400) begin
      nerr++;
      $display("FAIL rts_seen: waited %0d cycles for request-to-send, want < 400", guard);
      return;
    end
    nvec++;
    if (ps2_data !== 1'b0) begin
      nerr++;
      $display("FAIL start_bit: line %b, want 0", ps2_data);
    end
    for (int k = 0; k < 11; k++) begin
      repeat (half / 2) @(negedge clk);
      if (k == 10) dev_data_low = ack_low;
      repeat (half - half / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      if (abort_after == k + 1) return;
      repeat (half) @(negedge clk);
      if (k < 10) got[k] = ps2_data;
      dev_clk_low = 1'b0;
    end
    repeat (half) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    nvec++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_ready: tx_ready=%b busy=%b after %0d cycles, want 1/0", tag, tx_ready, busy, guard);
    end
  endtask

  // One complete frame with all checks; used by several scenarios.
  task automatic full_frame(input string tag, input logic [7:0] d, input bit ack_low);
    logic [9:0] got;
    int n, d0, a0;
    d0 = done_cnt;
    a0 = ack_err_cnt;
    send(d);
    measure_inhibit(n);
    nvec++;
    if (n != int'(INH)) begin
      nerr++;
      $display("FAIL %s_inhibit: clk held low %0d cycles, want %0d", tag, n, INH);
    end
    device_run(ack_low, 0, got);
    nvec++;
    if (got !== model_frame(d)) begin
      nerr++;
      $display("FAIL %s_frame: sampled %b, want %b", tag, got, model_frame(d));
    end
    wait_ready(tag);
    nvec++;
    if ((done_cnt - d0) != (ack_low ? 1 : 0) || (ack_err_cnt - a0) != (ack_low ? 0 : 1)) begin
      nerr++;
      $display("FAIL %s_result: done x%0d ack_err x%0d, want x%0d x%0d", tag,
               done_cnt - d0, ack_err_cnt - a0, ack_low ? 1 : 0, ack_low ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    #2 clrn = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({tx_ready, busy, done, ack_err, timeout, ps2_clk_drive_low, ps2_data_drive_low} !== 7'b1000000) begin
      nerr++;
      $display("FAIL reset_outputs: %b, want 1000000",
               {tx_ready, busy, done, ack_err, timeout, ps2_clk_drive_low, ps2_data_drive_low});
    end
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    nvec++;
    if ({tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low} !== 4'b1000) begin
      nerr++;
      $display("FAIL reset_exit: %b, want 1000",
               {tx_ready, busy, ps2_clk_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_f4_ack();
    half = 20;
    full_frame("f4", 8'hF4, 1'b1);
  endtask

  task automatic test_ed_ack();
    half = 20;
    full_frame("ed", 8'hED, 1'b1);
  endtask

  task automatic test_ack_error();
    half = 20;
    full_frame("nack00", 8'h00, 1'b0);
  endtask

  task automatic test_timeout();
    int n, cyc, guard, d0, a0, t0;
    d0 = done_cnt; a0 = ack_err_cnt; t0 = timeout_cnt;
    send(8'h01);
    measure_inhibit(n);
    guard = 0;
    while (ps2_clk_drive_low !== 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    nvec++;
    if (cyc != int'(TMO)) begin
      nerr++;
      $display("FAIL timeout_latency: %0d cycles after release, want %0d", cyc, TMO);
    end
    nvec++;
    if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== 3'b000) begin
      nerr++;
      $display("FAIL timeout_lines: clk_dl/data_dl/busy=%b, want 000",
               {ps2_clk_drive_low, ps2_data_drive_low, busy});
    end
    @(negedge clk);
    nvec++;
    if (tx_ready !== 1'b1 || (timeout_cnt - t0) != 1 || done_cnt != d0 || ack_err_cnt != a0) begin
      nerr++;
      $display("FAIL timeout_idle: tx_ready=%b timeout x%0d done x%0d ack_err x%0d, want 1 x1 x0 x0",
               tx_ready, timeout_cnt - t0, done_cnt - d0, ack_err_cnt - a0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] got;
    int n;
    half = 20;
    send(8'hAA);
    measure_inhibit(n);
    device_run(1'b1, 5, got);
    repeat (6) @(negedge clk);
    nvec++;
    if (ps2_data_drive_low !== 1'b1) begin
      nerr++;
      $display("FAIL midframe_bit4: data_dl=%b, want 1", ps2_data_drive_low);
    end
    #2 clrn = 1'b0;
    #1;
    nvec++;
    if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
      nerr++;
      $display("FAIL midframe_async_release: clk_dl/data_dl=%b, want 00",
               {ps2_clk_drive_low, ps2_data_drive_low});
    end
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (tx_ready !== 1'b1) begin
      nerr++;
      $display("FAIL midframe_ready: tx_ready=%b, want 1", tx_ready);
    end
    full_frame("after_rst55", 8'h55, 1'b1);
  endtask

  task automatic test_ignore_busy_valid();
    logic [9:0] got;
    int n, spurious;
    bit was_busy;
    half = 20;
    send(8'hF4);
    measure_inhibit(n);
    fork
      device_run(1'b1, 0, got);
      begin
        repeat (half * 8) @(negedge clk);
        was_busy = busy;
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    nvec++;
    if (was_busy !== 1'b1 || got !== model_frame(8'hF4)) begin
      nerr++;
      $display("FAIL busy_valid_frame: busy=%b sampled %b, want 1 %b", was_busy, got, model_frame(8'hF4));
    end
    wait_ready("busy_valid");
    spurious = 0;
    repeat (30) @(negedge clk) if (ps2_clk_drive_low !== 1'b0 || busy !== 1'b0) spurious++;
    nvec++;
    if (spurious != 0) begin
      nerr++;
      $display("FAIL busy_valid_no_resend: %0d busy cycles after frame, want 0", spurious);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bit ack;
    for (int i = 0; i < 6; i++) begin
      d    = 8'($urandom);
      ack  = 1'($urandom_range(0, 1));
      half = int'($urandom_range(14, 24));
      full_frame($sformatf("rnd%0d_%02h", i, d), d, ack);
    end
  endtask

  task automatic test_pulse_exclusive();
    nvec++;
    if (viol_cnt != 0) begin
      nerr++;
      $display("FAIL pulse_exclusive: %0d cycles with overlapping pulses or pulse with ready, want 0", viol_cnt);
    end
  endtask

  initial begin
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    clrn         = 1'b1;
    test_reset();
    test_f4_ack();
    test_ed_ack();
    test_ack_error();
    test_timeout();
    test_reset_midframe();
    test_ignore_busy_valid();
    test_back_to_back();
    test_pulse_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
